// File: rtl/id_stage.sv
// RV32I decode stage: field/control decode, regfile addressing, load-use stall and the ID/EX register.
// Optional macro ID_MEXT_EN decodes OP with funct7=0000001 as MULDIV; otherwise that encoding is illegal.
module id_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               d_instruction_i,
  input  logic [DATA_WIDTH-1:0]     d_pc_i,
  input  logic [DATA_WIDTH-1:0]     d_pc4_i,
  input  logic                      brj_i,
  input  logic                      stall_general_i,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  output logic                      stall_o,
  output logic [DATA_WIDTH-1:0]     e_pc_o,
  output logic [DATA_WIDTH-1:0]     e_pc4_o,
  output logic [DATA_WIDTH-1:0]     e_rs1_data_o,
  output logic [DATA_WIDTH-1:0]     e_rs2_data_o,
  output logic [DATA_WIDTH-1:0]     e_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] e_rd_addr_o,
  output logic [2:0]                e_funct3_o,
  output logic                      e_funct7b5_o,
  output logic [3:0]                e_op_class_o,
  output logic                      e_reg_we_o,
  output logic                      e_mem_re_o,
  output logic                      e_mem_we_o,
  output logic                      e_illegal_o
);

  localparam logic [3:0] CLS_LUI    = 4'd1;
  localparam logic [3:0] CLS_AUIPC  = 4'd2;
  localparam logic [3:0] CLS_JAL    = 4'd3;
  localparam logic [3:0] CLS_JALR   = 4'd4;
  localparam logic [3:0] CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_LOAD   = 4'd6;
  localparam logic [3:0] CLS_STORE  = 4'd7;
  localparam logic [3:0] CLS_OPIMM  = 4'd8;
  localparam logic [3:0] CLS_OP     = 4'd9;
  localparam logic [3:0] CLS_MULDIV = 4'd10;
  localparam logic [3:0] CLS_SYSTEM = 4'd11;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc4;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic                      funct7b5;
    logic [3:0]                op_class;
    logic                      reg_we;
    logic                      mem_re;
    logic                      mem_we;
    logic                      illegal;
  } ex_t;

  ex_t ex_q, ex_d, dec;
  logic        use_rs1, use_rs2, wb;
  logic signed [31:0] imm32;
  logic [31:0] ins;

  assign ins        = d_instruction_i;
  assign rs1_addr_o = ins[19:15];
  assign rs2_addr_o = ins[24:20];

  always_comb begin
    dec          = '0;
    dec.pc       = d_pc_i;
    dec.pc4      = d_pc4_i;
    dec.rs1_data = rs1_data_i;
    dec.rs2_data = rs2_data_i;
    dec.rd       = ins[11:7];
    dec.funct3   = ins[14:12];
    dec.funct7b5 = ins[30];
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    wb           = 1'b0;
    imm32        = '0;
    case (ins[6:0])
      7'b0110111: begin dec.op_class = CLS_LUI;   wb = 1'b1; imm32 = {ins[31:12], 12'b0}; end
      7'b0010111: begin dec.op_class = CLS_AUIPC; wb = 1'b1; imm32 = {ins[31:12], 12'b0}; end
      7'b1101111: begin
        dec.op_class = CLS_JAL; wb = 1'b1;
        imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin
        dec.op_class = CLS_JALR; wb = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1100011: begin
        dec.op_class = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0000011: begin
        dec.op_class = CLS_LOAD; wb = 1'b1; use_rs1 = 1'b1; dec.mem_re = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0100011: begin
        dec.op_class = CLS_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.mem_we = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0010011: begin
        dec.op_class = CLS_OPIMM; wb = 1'b1; use_rs1 = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0110011: begin
        if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000) begin
          dec.op_class = CLS_OP; wb = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
`ifdef ID_MEXT_EN
        end else if (ins[31:25] == 7'b0000001) begin
          dec.op_class = CLS_MULDIV; wb = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
`endif
        end else begin
          dec.op_class = CLS_ILL;
          dec.illegal  = 1'b1;
        end
      end
      7'b1110011, 7'b0001111: begin
        dec.op_class = CLS_SYSTEM;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      default: begin
        dec.op_class = CLS_ILL;
        dec.illegal  = 1'b1;
      end
    endcase
    dec.imm    = DATA_WIDTH'(imm32);
    dec.reg_we = wb & (dec.rd != '0);
  end

  // A load in EX whose result the instruction in ID needs costs exactly one bubble.
  assign stall_o = ex_q.mem_re & (ex_q.rd != '0) & ~brj_i &
                   ((use_rs1 & (rs1_addr_o == ex_q.rd)) | (use_rs2 & (rs2_addr_o == ex_q.rd)));

  always_comb begin
    ex_d = ex_q;
    if (!stall_general_i) begin
      if (brj_i || stall_o) ex_d = '0;
      else                  ex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign e_pc_o       = ex_q.pc;
  assign e_pc4_o      = ex_q.pc4;
  assign e_rs1_data_o = ex_q.rs1_data;
  assign e_rs2_data_o = ex_q.rs2_data;
  assign e_imm_o      = ex_q.imm;
  assign e_rd_addr_o  = ex_q.rd;
  assign e_funct3_o   = ex_q.funct3;
  assign e_funct7b5_o = ex_q.funct7b5;
  assign e_op_class_o = ex_q.op_class;
  assign e_reg_we_o   = ex_q.reg_we;
  assign e_mem_re_o   = ex_q.mem_re;
  assign e_mem_we_o   = ex_q.mem_we;
  assign e_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed cases then randomized traffic against an instruction-level model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_instruction_i = 32'h0;
  logic [31:0] d_pc_i = 32'h0, d_pc4_i = 32'h0;
  logic        brj_i = 1'b0, stall_general_i = 1'b0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i = 32'h0, rs2_data_i = 32'h0;
  logic        stall_o;
  logic [31:0] e_pc_o, e_pc4_o, e_rs1_data_o, e_rs2_data_o, e_imm_o;
  logic [4:0]  e_rd_addr_o;
  logic [2:0]  e_funct3_o;
  logic        e_funct7b5_o;
  logic [3:0]  e_op_class_o;
  logic        e_reg_we_o, e_mem_re_o, e_mem_we_o, e_illegal_o;

  id_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .d_instruction_i(d_instruction_i), .d_pc_i(d_pc_i), .d_pc4_i(d_pc4_i),
    .brj_i(brj_i), .stall_general_i(stall_general_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o),
    .e_pc_o(e_pc_o), .e_pc4_o(e_pc4_o),
    .e_rs1_data_o(e_rs1_data_o), .e_rs2_data_o(e_rs2_data_o),
    .e_imm_o(e_imm_o), .e_rd_addr_o(e_rd_addr_o),
    .e_funct3_o(e_funct3_o), .e_funct7b5_o(e_funct7b5_o),
    .e_op_class_o(e_op_class_o), .e_reg_we_o(e_reg_we_o),
    .e_mem_re_o(e_mem_re_o), .e_mem_we_o(e_mem_we_o), .e_illegal_o(e_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, pc4, d1, d2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [3:0]  cls;
    logic        we, re, mwe, ill;
  } exp_t;

  exp_t exp_q[$];
  logic stall_q[$];
  exp_t model;
  logic model_known = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int class_of(input logic [31:0] ins);
    case (ins & 32'h7F)
      32'h37: return 1;
      32'h17: return 2;
      32'h6F: return 3;
      32'h67: return 4;
      32'h63: return 5;
      32'h03: return 6;
      32'h23: return 7;
      32'h13: return 8;
      32'h33: begin
        if ((ins >> 25) == 0 || (ins >> 25) == 32) return 9;
`ifdef ID_MEXT_EN
        if ((ins >> 25) == 1) return 10;
`endif
        return 15;
      end
      32'h73, 32'h0F: return 11;
      default: return 15;
    endcase
  endfunction

  // Immediates built arithmetically from field values and a sign word.
  function automatic logic [31:0] imm_of(input logic [31:0] ins, input int cls);
    logic [31:0] sx;
    sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (cls)
      1, 2:       return ins & 32'hFFFF_F000;
      3:          return sx * 32'h10_0000 + ((ins >> 12) & 255) * 4096 + ((ins >> 20) & 1) * 2048 + ((ins >> 21) & 1023) * 2;
      4, 6, 8, 11: return sx * 4096 + (ins >> 20);
      5:          return sx * 4096 + ((ins >> 7) & 1) * 2048 + ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2;
      7:          return sx * 2048 + ((ins >> 25) & 63) * 32 + ((ins >> 7) & 31);
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic uses_rs1(input int cls);
    return cls inside {4, 5, 6, 7, 8, 9, 10};
  endfunction

  function automatic logic uses_rs2(input int cls);
    return cls inside {5, 7, 9, 10};
  endfunction

  function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    int   cls;
    cls    = class_of(ins);
    e.pc   = pc;
    e.pc4  = pc + 4;
    e.d1   = d1;
    e.d2   = d2;
    e.imm  = imm_of(ins, cls);
    e.rd   = ins[11:7];
    e.f3   = ins[14:12];
    e.f7b5 = ins[30];
    e.cls  = 4'(cls);
    e.we   = (cls inside {1, 2, 3, 4, 6, 8, 9, 10}) && (ins[11:7] != 0);
    e.re   = (cls == 6);
    e.mwe  = (cls == 7);
    e.ill  = (cls == 15);
    return e;
  endfunction

  logic exp_stall;

  // Drives one cycle of inputs and pushes the expected stall and next E contents.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input logic brj, input logic sg, input logic r);
    int cls;
    @(negedge clk);
    d_instruction_i = ins;
    d_pc_i          = pc;
    d_pc4_i         = pc + 4;
    brj_i           = brj;
    stall_general_i = sg;
    rst             = r;
    rs1_data_i      = $urandom;
    rs2_data_i      = $urandom;
    #1;
    cls = class_of(ins);
    exp_stall = 1'b0;
    if (model_known) begin
      exp_stall = model.re && model.rd != 0 && !brj &&
                  ((uses_rs1(cls) && ins[19:15] == model.rd) || (uses_rs2(cls) && ins[24:20] == model.rd));
      stall_q.push_back(exp_stall);
    end
    if (r) begin
      model = '0;
      model_known = 1'b1;
    end else if (model_known && !sg) begin
      if (brj || exp_stall) model = '0;
      else                  model = decode(ins, pc, rs1_data_i, rs2_data_i);
    end
    if (model_known) exp_q.push_back(model);
  endtask

  initial begin : stall_monitor
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        checkOutput("stall_o", {31'b0, stall_o}, {31'b0, s});
      end
    end
  end

  initial begin : e_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("e_pc", e_pc_o, e.pc);
        checkOutput("e_pc4", e_pc4_o, e.pc4);
        checkOutput("e_rs1_data", e_rs1_data_o, e.d1);
        checkOutput("e_rs2_data", e_rs2_data_o, e.d2);
        if (e.cls != 4'd11) checkOutput("e_imm", e_imm_o, e.imm);
        checkOutput("e_rd", {27'b0, e_rd_addr_o}, {27'b0, e.rd});
        checkOutput("e_funct3", {29'b0, e_funct3_o}, {29'b0, e.f3});
        checkOutput("e_funct7b5", {31'b0, e_funct7b5_o}, {31'b0, e.f7b5});
        checkOutput("e_op_class", {28'b0, e_op_class_o}, {28'b0, e.cls});
        checkOutput("e_reg_we", {31'b0, e_reg_we_o}, {31'b0, e.we});
        checkOutput("e_mem_re", {31'b0, e_mem_re_o}, {31'b0, e.re});
        checkOutput("e_mem_we", {31'b0, e_mem_we_o}, {31'b0, e.mwe});
        checkOutput("e_illegal", {31'b0, e_illegal_o}, {31'b0, e.ill});
      end
    end
  end

  function automatic logic [31:0] random_instr();
    logic [31:0] ins;
    logic [6:0]  opc [12];
    int          pick;
    opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h33};
    ins  = $urandom;
    pick = $urandom_range(0, 13);
    if (pick < 12) ins[6:0] = opc[pick];
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    if (ins[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'b0000000;
        1: ins[31:25] = 7'b0100000;
        2: ins[31:25] = 7'b0000001;
        default: ;
      endcase
    end
    return ins;
  endfunction

  initial begin : driver
    logic [31:0] ins, pc;
    logic        hold;
    applyStimulus(32'h0000_0013, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0000_0013, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0050_0093, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_A103, 32'h14, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h18, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h18, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0050_0093, 32'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0050_0093, 32'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0050_0093, 32'h24, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'hFE20_8EE3, 32'h28, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0080_006F, 32'h2C, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h30, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0220_81B3, 32'h34, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_A103, 32'h38, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h3C, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0021_01B3, 32'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000_A103, 32'h40, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h44, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0021_01B3, 32'h44, 1'b0, 1'b0, 1'b0);

    pc   = 32'h100;
    ins  = random_instr();
    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        ins = random_instr();
        pc  = pc + 4;
      end
      applyStimulus(ins, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 49) == 0));
      hold = exp_stall || stall_general_i;
    end

    repeat (3) @(negedge clk);
    checkOutput("queues_drained", 32'(exp_q.size() + stall_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage.
- Consumes the fetched instruction, PC and PC+4 each cycle, decodes RV32I fields and control, and drives register-file read addresses.
- Registers operands, immediate and control into the ID/EX pipeline register.
- Detects load-use hazards and asserts a one-cycle stall that feeds the fetch stage's stall_i.

Parameters:
DATA_WIDTH, 32, datapath/PC width (matches `DATA_WIDTH)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
d_instruction_i  input  32  instruction from fetch stage
d_pc_i  input  DATA_WIDTH  PC of d_instruction_i
d_pc4_i  input  DATA_WIDTH  PC+4 of d_instruction_i
brj_i  input  1  taken branch/jump from EX; flush
stall_general_i  input  1  multi-cycle core stall; hold
rs1_addr_o  output  5  regfile read address 1 (combinational)
rs2_addr_o  output  5  regfile read address 2 (combinational)
rs1_data_i  input  DATA_WIDTH  regfile read data 1
rs2_data_i  input  DATA_WIDTH  regfile read data 2
stall_o  output  1  load-use stall request (combinational)
e_pc_o  output  DATA_WIDTH  registered PC
e_pc4_o  output  DATA_WIDTH  registered PC+4
e_rs1_data_o  output  DATA_WIDTH  registered operand 1
e_rs2_data_o  output  DATA_WIDTH  registered operand 2
e_imm_o  output  DATA_WIDTH  registered sign-extended immediate
e_rd_addr_o  output  5  registered destination register
e_funct3_o  output  3  registered funct3
e_funct7b5_o  output  1  registered instr[30]
e_op_class_o  output  4  registered class: 0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 MULDIV, 11 SYSTEM/FENCE, 15 ILLEGAL
e_reg_we_o  output  1  registered writeback enable
e_mem_re_o  output  1  registered load flag
e_mem_we_o  output  1  registered store flag
e_illegal_o  output  1  registered illegal-instruction flag

Behaviour:
- Reset: when rst=1 at a clock edge, all e_* outputs go to 0. Class 0 is NOP, so there is no writeback and no memory access.
- Register addresses:
  - rs1_addr_o = instr[19:15], rs2_addr_o = instr[24:20], driven from d_instruction_i every cycle.
  - The regfile is read combinationally in the same cycle.
- Latency: one cycle from d_instruction_i to e_*.
- Immediate formats:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All sign-extended to DATA_WIDTH from bit 31. R-type imm = 0.
- Classification:
  - Classes are decoded from opcode[6:0].
  - Unknown opcode, or instr[1:0] != 2'b11, gives class 15 and e_illegal_o=1, with reg_we/mem_re/mem_we = 0.
  - OP with funct7 other than 0000000 or 0100000 is illegal (but see the optional feature).
- reg_we:
  - Set for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, MULDIV.
  - Forced to 0 when rd = 0.
- Operand use:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OPIMM, OP, MULDIV.
  - rs2 is used by BRANCH, STORE, OP, MULDIV.
- Load-use hazard:
  - stall_o = e_mem_re_o & (e_rd_addr_o != 0) & ((rs1 used & rs1_addr_o == e_rd_addr_o) | (rs2 used & rs2_addr_o == e_rd_addr_o)) & !brj_i.
  - Lasts exactly one cycle. The fetch stage re-presents the same instruction on the next cycle, after which the match clears because E then holds a bubble.
- Pipeline register priority, highest first:
  1. rst: clear all e_* outputs.
  2. stall_general_i: hold all e_* outputs unchanged. Also overrides brj_i.
  3. brj_i: load a bubble (all e_* = 0).
  4. stall_o: load a bubble.
  5. Otherwise: load the decoded instruction.
- stall_general_i and stall_o together: hold wins; stall_o remains asserted for the next cycle if the hazard persists.
- Reset mid-stall or mid-flush: the next state is reset, with no residual stall.

Optional Feature:
- Macro: ID_MEXT_EN.
- Defined: OP with funct7 = 0000001 decodes as class 10 (MULDIV), with reg_we rules as for OP.
- Undefined: that encoding is class 15 with e_illegal_o=1.

Test Plan:
- addi x1,x0,5 (0x00500093), PC=0x10 -> next cycle e_op_class_o=8, e_rd_addr_o=1, e_imm_o=5, e_reg_we_o=1, e_pc_o=0x10, e_pc4_o=0x14.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3) -> stall_o=1 for exactly one cycle, E holds class 0 for that cycle, then class 9 with rd=3.
- brj_i=1 with 0x00500093 at input -> next cycle all e_* = 0. The same case with stall_general_i=1 -> e_* unchanged.
- Branch beq x1,x2,-4 (0xFE208EE3) -> e_imm_o=0xFFFFFFFC, class 5, reg_we=0. jal x0,8 (0x0080006F) -> imm=8, reg_we=0 because rd=0.
- Input 0xFFFFFFFF -> e_illegal_o=1, class 15. mul x3,x1,x2 (0x022081B3) -> class 10 with ID_MEXT_EN defined, class 15 without it.
- rst=1 asserted during a pending load-use stall -> the next cycle all e_* = 0 and stall_o=0.
